reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Register file with a pending-write scoreboard, a write-to-read bypass
// and a sequential clear sweep that runs across every register.
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int READ_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [XLEN-1:0]   wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              busy1,
    output logic              busy2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int NREG = 1 << ADDR_W;
    localparam bit ZEN  = (ZERO_REG != 0);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NREG - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] idx;
    logic [XLEN-1:0]   regs [NREG];
    logic [NREG-1:0]   busy;
    logic              in_clr, wv, iv;

    assign in_clr   = (state == CLEAR);
    assign idx      = cnt[ADDR_W-1:0];
    assign wv       = we && !in_clr && !(ZEN && wa == '0);
    assign iv       = iss_valid && !in_clr && !(ZEN && iss_rd == '0);
    assign clr_busy = in_clr;
    assign clr_done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && clr_req)
                cnt <= '0;
            else if (in_clr)
                cnt <= cnt + (ADDR_W+1)'(1);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (clr_req) state_nx = CLEAR;
            CLEAR:   if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (in_clr) begin
            regs[idx] <= '0;
        end else if (wv) begin
            regs[wa] <= wd;
        end
    end

    // An issue landing on the register being written keeps it busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else if (in_clr) begin
            busy[idx] <= 1'b0;
        end else begin
            if (wv) busy[wa] <= 1'b0;
            if (iv) busy[iss_rd] <= 1'b1;
        end
    end

    logic [XLEN-1:0] rd1_c, rd2_c;
    logic            bz1_c, bz2_c;

    always_comb begin
        rd1_c = regs[ra1];
        bz1_c = busy[ra1];
        rd2_c = regs[ra2];
        bz2_c = busy[ra2];
        if (wv && wa == ra1) begin
            rd1_c = wd;
            bz1_c = 1'b0;
        end
        if (wv && wa == ra2) begin
            rd2_c = wd;
            bz2_c = 1'b0;
        end
        if (ZEN && ra1 == '0) begin
            rd1_c = '0;
            bz1_c = 1'b0;
        end
        if (ZEN && ra2 == '0) begin
            rd2_c = '0;
            bz2_c = 1'b0;
        end
    end

    if (READ_REG != 0) begin : g_rreg
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd1   <= '0;
                rd2   <= '0;
                busy1 <= 1'b0;
                busy2 <= 1'b0;
            end else begin
                rd1   <= rd1_c;
                rd2   <= rd2_c;
                busy1 <= bz1_c;
                busy2 <= bz2_c;
            end
        end
    end else begin : g_rcomb
        assign rd1   = rd1_c;
        assign rd2   = rd2_c;
        assign busy1 = bz1_c;
        assign busy2 = bz2_c;
    end

endmodule
